// File: rtl/message_scroller_if.sv
// Bus bundle between a message source (master) and the message_scroller (slave):
// buffer writes, commit/step controls and the digit window back to the display side.
interface message_scroller_if #(
    parameter int MAX_LEN      = 32,
    parameter int CHAR_WIDTH   = 8,
    parameter int NUM_DISPLAYS = 6
);
    localparam int ADDR_W = $clog2(MAX_LEN);
    localparam int LEN_W  = $clog2(MAX_LEN + 1);

    logic                               wr_en;
    logic [ADDR_W-1:0]                  wr_addr;
    logic [CHAR_WIDTH-1:0]              wr_data;
    logic                               commit;
    logic [LEN_W-1:0]                   commit_len;
    logic                               step_en;
    logic                               scroll_dir;
    logic                               hold;
    logic [NUM_DISPLAYS*CHAR_WIDTH-1:0] display_chars;
    logic                               wrap;
    logic                               commit_err;
    logic                               running;

    modport master (
        output wr_en, wr_addr, wr_data, commit, commit_len, step_en, scroll_dir, hold,
        input  display_chars, wrap, commit_err, running
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, commit, commit_len, step_en, scroll_dir, hold,
        output display_chars, wrap, commit_err, running
    );
endinterface

// File: rtl/message_scroller.sv
// Loadable ASCII message buffer that scrolls a NUM_DISPLAYS-wide character window
// over a virtual tape (message followed by NUM_DISPLAYS blanks) for the HEX bank.
module message_scroller #(
    parameter int                    MAX_LEN      = 32,
    parameter int                    CHAR_WIDTH   = 8,
    parameter int                    NUM_DISPLAYS = 6,
    parameter logic [CHAR_WIDTH-1:0] BLANK_CHAR   = 8'h20
) (
    input logic               clk,
    input logic               rst_n,
    message_scroller_if.slave bus
);
    localparam int ADDR_W = $clog2(MAX_LEN);
    localparam int LEN_W  = $clog2(MAX_LEN + 1);
    localparam int POS_W  = $clog2(MAX_LEN + NUM_DISPLAYS);
    // One extra bit so the tape length and pos+offset never overflow.
    localparam int TAPE_W = POS_W + 1;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    localparam logic [ADDR_W:0]   ADDR_LIMIT = (ADDR_W + 1)'(MAX_LEN);
    localparam logic [LEN_W-1:0]  LEN_LIMIT  = LEN_W'(MAX_LEN);
    localparam logic [TAPE_W-1:0] PAD_LEN    = TAPE_W'(NUM_DISPLAYS);

    logic [CHAR_WIDTH-1:0]              buffer [MAX_LEN];
    logic [1:0]                         state;
    logic [LEN_W-1:0]                   len;
    logic [POS_W-1:0]                   pos;
    logic                               wrap_p1;
    logic                               commit_err_p1;
    logic [NUM_DISPLAYS*CHAR_WIDTH-1:0] disp_p0;
    logic [NUM_DISPLAYS*CHAR_WIDTH-1:0] disp_p1;

    logic [TAPE_W-1:0] len_ext;
    logic [TAPE_W-1:0] tape_len;
    logic [POS_W-1:0]  last_pos;
    logic              at_end;
    logic              at_start;

    // Tape position of a digit: both operands are below t, so one subtract is a full mod.
    function automatic logic [TAPE_W-1:0] tape_index(
        input logic [POS_W-1:0]  p,
        input logic [TAPE_W-1:0] off,
        input logic [TAPE_W-1:0] t
    );
        logic [TAPE_W-1:0] sum;
        sum = TAPE_W'(p) + off;
        if (sum >= t) begin
            sum = sum - t;
        end
        return sum;
    endfunction

    function automatic logic [CHAR_WIDTH-1:0] tape_char(
        input logic [TAPE_W-1:0]   idx,
        input logic [TAPE_W-1:0]   l,
        input logic [CHAR_WIDTH-1:0] stored
    );
        return (idx < l) ? stored : BLANK_CHAR;
    endfunction

    assign len_ext  = TAPE_W'(len);
    assign tape_len = len_ext + PAD_LEN;
    assign last_pos = POS_W'(tape_len - TAPE_W'(1));
    assign at_end   = (pos == last_pos);
    assign at_start = (pos == '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                buffer[i] <= BLANK_CHAR;
            end
        end else if (bus.wr_en && ({1'b0, bus.wr_addr} < ADDR_LIMIT)) begin
            buffer[bus.wr_addr] <= bus.wr_data;
        end
    end

    // Commit takes priority over any step in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= ST_EMPTY;
            len           <= '0;
            pos           <= '0;
            wrap_p1       <= 1'b0;
            commit_err_p1 <= 1'b0;
        end else begin
            wrap_p1       <= 1'b0;
            commit_err_p1 <= 1'b0;
            if (bus.commit) begin
                if (bus.commit_len > LEN_LIMIT) begin
                    commit_err_p1 <= 1'b1;
                end else if (bus.commit_len == '0) begin
                    state <= ST_EMPTY;
                    len   <= '0;
                    pos   <= '0;
                end else begin
                    len   <= bus.commit_len;
                    pos   <= '0;
                    state <= bus.hold ? ST_HOLD : ST_RUN;
                end
            end else begin
                case (state)
                    ST_RUN: begin
                        if (bus.hold) begin
                            state <= ST_HOLD;
                        end else if (bus.step_en) begin
                            if (bus.scroll_dir) begin
                                pos     <= at_end ? '0 : pos + 1'b1;
                                wrap_p1 <= at_end;
                            end else begin
                                pos     <= at_start ? last_pos : pos - 1'b1;
                                wrap_p1 <= at_start;
                            end
                        end
                    end
                    ST_HOLD: begin
                        if (!bus.hold) begin
                            state <= ST_RUN;
                        end
                    end
                    ST_EMPTY: begin
                        state <= ST_EMPTY;
                    end
                    default: begin
                        state <= ST_EMPTY;
                    end
                endcase
            end
        end
    end

    // Stage p0: window lookup from buffer, L and pos.
    always_comb begin
        logic [TAPE_W-1:0] idx;
        disp_p0 = '0;
        idx     = '0;
        for (int d = 0; d < NUM_DISPLAYS; d++) begin
            idx = tape_index(pos, TAPE_W'(NUM_DISPLAYS - 1 - d), tape_len);
            if (state == ST_EMPTY) begin
                disp_p0[d*CHAR_WIDTH +: CHAR_WIDTH] = BLANK_CHAR;
            end else begin
                disp_p0[d*CHAR_WIDTH +: CHAR_WIDTH] =
                    tape_char(idx, len_ext, buffer[idx[ADDR_W-1:0]]);
            end
        end
    end

    // Stage p1: registered window.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            disp_p1 <= {NUM_DISPLAYS{BLANK_CHAR}};
        end else begin
            disp_p1 <= disp_p0;
        end
    end

    assign bus.display_chars = disp_p1;
    assign bus.wrap          = wrap_p1;
    assign bus.commit_err    = commit_err_p1;
    assign bus.running       = (state == ST_RUN);
endmodule

// File: tb/tb_message_scroller.sv
// Directed bench for message_scroller: a vector table for load/scroll/commit cases,
// plus hand-written sequences for reset, hold and the full-length buffer.
module tb_message_scroller;
    localparam int MAX_LEN = 32;
    localparam int CW      = 8;
    localparam int ND      = 6;
    localparam int AW      = $clog2(MAX_LEN);
    localparam int LW      = $clog2(MAX_LEN + 1);
    localparam logic [47:0] BLANK6 = {6{8'h20}};

    typedef struct {
        logic          rst_n;
        logic          wr_en;
        logic [AW-1:0] wr_addr;
        logic [7:0]    wr_data;
        logic          commit;
        logic [LW-1:0] commit_len;
        logic          step;
        logic          dir;
        logic          hold;
        logic [47:0]   exp_disp;
        logic          exp_wrap;
        logic          exp_err;
        logic          exp_run;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_fail = 0;
    vec_t tbl[$];
    logic [7:0] mbuf [MAX_LEN];

    always #5 clk = ~clk;

    message_scroller_if #(.MAX_LEN(MAX_LEN), .CHAR_WIDTH(CW), .NUM_DISPLAYS(ND)) bus ();

    message_scroller #(
        .MAX_LEN(MAX_LEN), .CHAR_WIDTH(CW), .NUM_DISPLAYS(ND), .BLANK_CHAR(8'h20)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    function automatic vec_t mk(input logic wr, input logic [AW-1:0] a, input logic [7:0] dt,
                                input logic cm, input logic [LW-1:0] ln, input logic st,
                                input logic dr, input logic hd, input logic [47:0] dsp,
                                input logic w, input logic e, input logic r);
        vec_t v;
        v.rst_n = 1'b1; v.wr_en = wr; v.wr_addr = a; v.wr_data = dt;
        v.commit = cm; v.commit_len = ln; v.step = st; v.dir = dr; v.hold = hd;
        v.exp_disp = dsp; v.exp_wrap = w; v.exp_err = e; v.exp_run = r;
        return v;
    endfunction

    task automatic add(input vec_t v);
        tbl.push_back(v);
    endtask

    function automatic logic [47:0] model_win(input int p, input int l);
        logic [47:0] w;
        int idx;
        w = '0;
        for (int d = 0; d < ND; d++) begin
            idx = (p + ND - 1 - d) % (l + ND);
            w[d*8 +: 8] = (idx < l) ? mbuf[idx] : 8'h20;
        end
        return w;
    endfunction

    task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input string tag);
        @(negedge clk);
        rst_n          = v.rst_n;
        bus.wr_en      = v.wr_en;
        bus.wr_addr    = v.wr_addr;
        bus.wr_data    = v.wr_data;
        bus.commit     = v.commit;
        bus.commit_len = v.commit_len;
        bus.step_en    = v.step;
        bus.scroll_dir = v.dir;
        bus.hold       = v.hold;
        @(posedge clk);
        #1;
        check({tag, " disp"}, bus.display_chars, v.exp_disp);
        check({tag, " wrap"}, {47'b0, bus.wrap}, {47'b0, v.exp_wrap});
        check({tag, " commit_err"}, {47'b0, bus.commit_err}, {47'b0, v.exp_err});
        check({tag, " running"}, {47'b0, bus.running}, {47'b0, v.exp_run});
    endtask

    initial begin
        vec_t v;
        int   mpos;

        bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0; bus.commit = 1'b0;
        bus.commit_len = '0; bus.step_en = 1'b0; bus.scroll_dir = 1'b1; bus.hold = 1'b0;

        // Load "HELLO"; the last write shares its cycle with the commit.
        add(mk(1, 0, 8'h48, 0, 0, 0, 1, 0, BLANK6, 0, 0, 0));
        add(mk(1, 1, 8'h45, 0, 0, 0, 1, 0, BLANK6, 0, 0, 0));
        add(mk(1, 2, 8'h4C, 0, 0, 0, 1, 0, BLANK6, 0, 0, 0));
        add(mk(1, 3, 8'h4C, 0, 0, 0, 1, 0, BLANK6, 0, 0, 0));
        add(mk(1, 4, 8'h4F, 1, 5, 0, 1, 0, BLANK6, 0, 0, 1));
        add(mk(0, 0, 0, 0, 0, 0, 1, 0, "HELLO ", 0, 0, 1));
        // Eleven forward steps around T=11; only the last one wraps.
        add(mk(0, 0, 0, 0, 0, 1, 1, 0, "HELLO ", 0, 0, 1));
        add(mk(0, 0, 0, 0, 0, 1, 1, 0, "ELLO  ", 0, 0, 1));
        add(mk(0, 0, 0, 0, 0, 1, 1, 0, "LLO   ", 0, 0, 1));
        add(mk(0, 0, 0, 0, 0, 1, 1, 0, "LO    ", 0, 0, 1));
        add(mk(0, 0, 0, 0, 0, 1, 1, 0, "O     ", 0, 0, 1));
        add(mk(0, 0, 0, 0, 0, 1, 1, 0, "      ", 0, 0, 1));
        add(mk(0, 0, 0, 0, 0, 1, 1, 0, "     H", 0, 0, 1));
        add(mk(0, 0, 0, 0, 0, 1, 1, 0, "    HE", 0, 0, 1));
        add(mk(0, 0, 0, 0, 0, 1, 1, 0, "   HEL", 0, 0, 1));
        add(mk(0, 0, 0, 0, 0, 1, 1, 0, "  HELL", 0, 0, 1));
        add(mk(0, 0, 0, 0, 0, 1, 1, 0, " HELLO", 1, 0, 1));
        add(mk(0, 0, 0, 0, 0, 0, 1, 0, "HELLO ", 0, 0, 1));
        // Backward step from 0 wraps to 10; forward from 10 wraps back to 0.
        add(mk(0, 0, 0, 0, 0, 1, 0, 0, "HELLO ", 1, 0, 1));
        add(mk(0, 0, 0, 0, 0, 0, 0, 0, " HELLO", 0, 0, 1));
        add(mk(0, 0, 0, 0, 0, 1, 1, 0, " HELLO", 1, 0, 1));
        add(mk(0, 0, 0, 0, 0, 0, 1, 0, "HELLO ", 0, 0, 1));
        // Oversize commit is rejected; commit beats a simultaneous step.
        add(mk(0, 0, 0, 1, 40, 0, 1, 0, "HELLO ", 0, 1, 1));
        add(mk(0, 0, 0, 0, 0, 0, 1, 0, "HELLO ", 0, 0, 1));
        add(mk(0, 0, 0, 0, 0, 1, 1, 0, "HELLO ", 0, 0, 1));
        add(mk(0, 0, 0, 0, 0, 0, 1, 0, "ELLO  ", 0, 0, 1));
        add(mk(0, 0, 0, 1, 5, 1, 1, 0, "ELLO  ", 0, 0, 1));
        add(mk(0, 0, 0, 0, 0, 0, 1, 0, "HELLO ", 0, 0, 1));
        // Write during RUN shows two edges later.
        add(mk(1, 0, 8'h4A, 0, 0, 0, 1, 0, "HELLO ", 0, 0, 1));
        add(mk(0, 0, 0, 0, 0, 0, 1, 0, "JELLO ", 0, 0, 1));
        add(mk(1, 0, 8'h48, 0, 0, 0, 1, 0, "JELLO ", 0, 0, 1));
        // Zero-length commit empties; a fresh commit restarts at pos 0.
        add(mk(0, 0, 0, 1, 0, 0, 1, 0, "HELLO ", 0, 0, 0));
        add(mk(0, 0, 0, 0, 0, 1, 1, 0, BLANK6, 0, 0, 0));
        add(mk(0, 0, 0, 1, 5, 0, 1, 0, BLANK6, 0, 0, 1));
        add(mk(0, 0, 0, 0, 0, 0, 1, 0, "HELLO ", 0, 0, 1));

        // Reset, then steps while EMPTY must leave everything blank.
        v = mk(0, 0, 0, 0, 0, 0, 1, 0, BLANK6, 0, 0, 0);
        v.rst_n = 1'b0;
        apply(v, "reset0");
        apply(v, "reset1");
        for (int i = 0; i < 100; i++) begin
            apply(mk(0, 0, 0, 0, 0, (i % 2 == 0), 1, 0, BLANK6, 0, 0, 0), $sformatf("empty%0d", i));
        end

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], $sformatf("t%0d", i));
        end

        // Hold freezes the window; after release each step moves exactly one place.
        apply(mk(0, 0, 0, 0, 0, 0, 1, 1, "HELLO ", 0, 0, 0), "hold_enter");
        for (int i = 0; i < 20; i++) begin
            apply(mk(0, 0, 0, 0, 0, 1, 1, 1, "HELLO ", 0, 0, 0), $sformatf("hold%0d", i));
        end
        apply(mk(0, 0, 0, 0, 0, 0, 1, 0, "HELLO ", 0, 0, 1), "hold_exit");
        apply(mk(0, 0, 0, 0, 0, 1, 1, 0, "HELLO ", 0, 0, 1), "rel_step1");
        apply(mk(0, 0, 0, 0, 0, 0, 1, 0, "ELLO  ", 0, 0, 1), "rel_idle1");
        apply(mk(0, 0, 0, 0, 0, 1, 1, 0, "ELLO  ", 0, 0, 1), "rel_step2");
        apply(mk(0, 0, 0, 0, 0, 0, 1, 0, "LLO   ", 0, 0, 1), "rel_idle2");

        // Full 32-character buffer: T=38, wrap on the 38th step.
        apply(mk(0, 0, 0, 1, 0, 0, 1, 0, "LLO   ", 0, 0, 0), "full_empty");
        for (int k = 0; k < MAX_LEN; k++) begin
            mbuf[k] = 8'h41 + k[7:0];
            apply(mk(1, k[AW-1:0], mbuf[k], 0, 0, 0, 1, 0, BLANK6, 0, 0, 0), $sformatf("full_wr%0d", k));
        end
        apply(mk(0, 0, 0, 1, 6'd32, 0, 1, 0, BLANK6, 0, 0, 1), "full_commit");
        mpos = 0;
        for (int s = 0; s < 41; s++) begin
            apply(mk(0, 0, 0, 0, 0, 1, 1, 0, model_win(mpos, MAX_LEN), (mpos == 37), 0, 1),
                  $sformatf("full_step%0d", s));
            mpos = (mpos == 37) ? 0 : mpos + 1;
        end

        // Reset mid-scroll aborts and clears the buffer.
        v = mk(0, 0, 0, 0, 0, 1, 1, 0, BLANK6, 0, 0, 0);
        v.rst_n = 1'b0;
        apply(v, "mid_reset");
        apply(mk(0, 0, 0, 1, 6'd32, 0, 1, 0, BLANK6, 0, 0, 1), "post_reset_commit");
        apply(mk(0, 0, 0, 0, 0, 0, 1, 0, BLANK6, 0, 0, 1), "post_reset_window");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
